err_collector: RTL and testbench

//  Synthesizable hardware counterpart of the sim-only assertion reporter: it receives error

---
 rtl/err_pkg.sv | 12 +
 rtl/err_log_fifo.sv | 83 ++++++++
 rtl/err_collector.sv | 148 ++++++++++++++
 tb/tb_err_collector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/err_pkg.sv
// Shared types and defaults for the error collector and its log FIFO.
package err_pkg;

  typedef enum logic [1:0] {
    ERR_IDLE  = 2'd0,
    ERR_COUNT = 2'd1,
    ERR_HALT  = 2'd2
  } err_state_t;

  localparam int ERR_FAIL_DELAY_DEFAULT = 50;

endpackage

// File: rtl/err_log_fifo.sv
// Synchronous FIFO holding {src, ts} error log entries; flush outranks push and pop.
module err_log_fifo
  import err_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign data_o  = mem_q[rd_q];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = {PTR_W{1'b0}};
      rd_d    = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_q] = data_i;
        wr_d        = wr_q + PTR_W'(1);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = rd_q + PTR_W'(1);
      end else begin
        rd_d = rd_q;
      end
      if (do_push_s && !do_pop_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop_s && !do_push_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= {PTR_W{1'b0}};
      rd_q    <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/err_collector.sv
// Logs timestamped checker error pulses and raises a sticky halt FAIL_DELAY cycles
// after the first accepted error.
module err_collector
  import err_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int FAIL_DELAY = ERR_FAIL_DELAY_DEFAULT,
  parameter int LOG_DEPTH  = 4,
  parameter int TS_W       = 16,
  parameter int CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic [NUM_SRC-1:0]         err_i,
  input  logic                       clr_i,
  output logic                       log_valid_o,
  input  logic                       log_ready_i,
  output logic [$clog2(NUM_SRC)-1:0] log_src_o,
  output logic [TS_W-1:0]            log_ts_o,
  output logic [CNT_W-1:0]           err_cnt_o,
  output logic                       overflow_o,
  output logic                       halt_pend_o,
  output logic                       halt_o
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int ENT_W = SRC_W + TS_W;
  localparam int DLY_W = (FAIL_DELAY > 1) ? $clog2(FAIL_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DLY_W-1:0] DLY_INIT = (FAIL_DELAY > 0) ? DLY_W'(FAIL_DELAY - 1) : {DLY_W{1'b0}};

  // Lowest set bit wins when several checkers fire together.
  function automatic logic [SRC_W-1:0] lowest_src(input logic [NUM_SRC-1:0] v);
    lowest_src = {SRC_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_src = SRC_W'(i);
      end else begin
        lowest_src = lowest_src;
      end
    end
  endfunction

  err_state_t       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             event_s, push_s, pop_s, log_full_s, log_empty_s;
  logic [ENT_W-1:0] head_s;

  assign event_s = en_i & (|err_i);
  assign push_s  = event_s & ~clr_i;
  assign pop_s   = ~log_empty_s & log_ready_i & ~clr_i;

  err_log_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clr_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  ({lowest_src(err_i), ts_q}),
    .data_o  (head_s),
    .full_o  (log_full_s),
    .empty_o (log_empty_s)
  );

  // Timestamp, saturating counter, overflow flag and halt FSM next-state.
  always_comb begin
    ts_d    = ts_q + TS_W'(1);
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    state_d = state_q;
    dly_d   = dly_q;
    if (clr_i) begin
      cnt_d   = {CNT_W{1'b0}};
      ovf_d   = 1'b0;
      state_d = ERR_IDLE;
      dly_d   = {DLY_W{1'b0}};
    end else begin
      if (event_s) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (log_full_s && !pop_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        ERR_IDLE: begin
          if (event_s && (FAIL_DELAY == 0)) begin
            state_d = ERR_HALT;
          end else if (event_s) begin
            state_d = ERR_COUNT;
            dly_d   = DLY_INIT;
          end else begin
            state_d = ERR_IDLE;
          end
        end
        ERR_COUNT: begin
          if (dly_q == {DLY_W{1'b0}}) begin
            state_d = ERR_HALT;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
        ERR_HALT: state_d = ERR_HALT;
        default:  state_d = ERR_IDLE;
      endcase
    end
  end

  // Registers; the timestamp is only cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ERR_IDLE;
      dly_q   <= {DLY_W{1'b0}};
      ts_q    <= {TS_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign log_valid_o            = ~log_empty_s;
  assign {log_src_o, log_ts_o}  = head_s;
  assign err_cnt_o              = cnt_q;
  assign overflow_o             = ovf_q;
  assign halt_pend_o            = (state_q == ERR_COUNT);
  assign halt_o                 = (state_q == ERR_HALT);

endmodule

// File: tb/tb_err_collector.sv
// Randomized and directed bench for err_collector against a queue-based reference model;
// dut_a uses FAIL_DELAY=50, dut_b FAIL_DELAY=0, both driven by the same inputs.
module tb_err_collector;

  localparam int DA = 50;
  localparam int DB = 0;

  logic       clk, rst_n, en, clr, ready;
  logic [7:0] err;

  logic        valid_a, ovf_a, pend_a, halt_a;
  logic [2:0]  src_a;
  logic [15:0] ts_a;
  logic [7:0]  cnt_a;
  logic        valid_b, ovf_b, pend_b, halt_b;
  logic [2:0]  src_b;
  logic [15:0] ts_b;
  logic [7:0]  cnt_b;

  err_collector #(.NUM_SRC(8), .FAIL_DELAY(DA), .LOG_DEPTH(4), .TS_W(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .err_i(err), .clr_i(clr),
    .log_valid_o(valid_a), .log_ready_i(ready), .log_src_o(src_a), .log_ts_o(ts_a),
    .err_cnt_o(cnt_a), .overflow_o(ovf_a), .halt_pend_o(pend_a), .halt_o(halt_a)
  );

  err_collector #(.NUM_SRC(8), .FAIL_DELAY(DB), .LOG_DEPTH(4), .TS_W(16), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .err_i(err), .clr_i(clr),
    .log_valid_o(valid_b), .log_ready_i(ready), .log_src_o(src_b), .log_ts_o(ts_b),
    .err_cnt_o(cnt_b), .overflow_o(ovf_b), .halt_pend_o(pend_b), .halt_o(halt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [18:0] q[$];
  logic [15:0] m_ts = 16'd0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  int cyc = 0;
  int first_a = -1;
  int first_b = -1;

  function automatic bit exp_pend(int first, int d);
    return (first >= 0) && ((cyc - first) >= 1) && ((cyc - first) <= d);
  endfunction

  function automatic bit exp_halt(int first, int d);
    return (first >= 0) && ((cyc - first) >= d + 1);
  endfunction

  // Apply the current inputs to the model, then advance one clock and settle.
  task automatic tick();
    bit ev, full, pop;
    logic [2:0] s;
    ev = en && (err != 8'h00);
    s = 3'd0;
    for (int i = 7; i >= 0; i--) if (err[i]) s = 3'(i);
    if (!rst_n) begin
      q.delete(); m_cnt = 0; m_ovf = 1'b0; first_a = -1; first_b = -1; m_ts = 16'd0;
    end else begin
      if (clr) begin
        q.delete(); m_cnt = 0; m_ovf = 1'b0; first_a = -1; first_b = -1;
      end else begin
        full = (q.size() == 4);
        pop  = (q.size() > 0) && ready;
        if (pop) void'(q.pop_front());
        if (ev) begin
          if (full && !pop) m_ovf = 1'b1;
          else q.push_back({s, m_ts});
          if (m_cnt < 255) m_cnt++;
          if (first_a < 0) first_a = cyc;
          if (first_b < 0) first_b = cyc;
        end
      end
      m_ts = m_ts + 16'd1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic do_clear();
    en = 1'b0; err = 8'h00; clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; err = 8'h00; clr = 1'b0; ready = 1'b0;
    do_reset();
    for (int i = 0; i < 100; i++) tick();
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", valid_a); end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d exp 0", cnt_a); end
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b exp 0", ovf_a); end
    total++; if ({pend_a, halt_a, pend_b, halt_b} !== 4'b0000) begin bad++;
      $display("FAIL reset_fsm: got %b exp 0000", {pend_a, halt_a, pend_b, halt_b}); end
    total++; if ({src_a, ts_a} !== 19'd0) begin bad++; $display("FAIL reset_head: got %0h exp 0", {src_a, ts_a}); end
  endtask

  task automatic test_single_event();
    ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && m_ts != 16'd10; i++) tick();
    en = 1'b1; err = 8'h01; tick(); err = 8'h00;
    total++; if ({valid_a, src_a, ts_a} !== {1'b1, 3'd0, 16'd10}) begin bad++;
      $display("FAIL single_entry: got v=%b src=%0d ts=%0d exp v=1 src=0 ts=10", valid_a, src_a, ts_a); end
    total++; if (cnt_a !== 8'd1) begin bad++; $display("FAIL single_cnt: got %0d exp 1", cnt_a); end
    for (int k = 1; k <= 60; k++) begin
      total++; if ({pend_a, halt_a} !== {exp_pend(first_a, DA), exp_halt(first_a, DA)}) begin bad++;
        $display("FAIL countdown k=%0d: got pend=%b halt=%b exp pend=%b halt=%b", k, pend_a, halt_a,
                 exp_pend(first_a, DA), exp_halt(first_a, DA)); end
      if (k < 60) tick();
    end
    total++; if ({pend_a, halt_a} !== 2'b01) begin bad++; $display("FAIL halt_sticky: got %b exp 01", {pend_a, halt_a}); end
    total++; if ({src_a, ts_a} !== {3'd0, 16'd10}) begin bad++; $display("FAIL head_hold: got %0h exp 0000a", {src_a, ts_a}); end
  endtask

  task automatic test_priority();
    do_clear();
    en = 1'b1; err = 8'b1010_0100; tick(); err = 8'h00;
    total++; if (src_a !== 3'd2) begin bad++; $display("FAIL prio_src: got %0d exp 2", src_a); end
    do_clear();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin err = 8'($urandom_range(1, 255)); tick(); end
    err = 8'h00;
    total++; if (cnt_a !== 8'd3) begin bad++; $display("FAIL held_cnt: got %0d exp 3", cnt_a); end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if ({valid_a, src_a, ts_a} !== {1'b1, q[0]}) begin bad++;
        $display("FAIL held_pop%0d: got %b/%0h exp 1/%0h", i, valid_a, {src_a, ts_a}, q[0]); end
      tick();
    end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL held_drained: got %b exp 0", valid_a); end
    ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_clear();
    ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin err = 8'($urandom_range(1, 255)); tick(); end
    err = 8'h00;
    total++; if ({valid_a, ovf_a, cnt_a} !== {1'b1, 1'b1, 8'd6}) begin bad++;
      $display("FAIL ovf_state: got v=%b o=%b c=%0d exp v=1 o=1 c=6", valid_a, ovf_a, cnt_a); end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({valid_a, src_a, ts_a} !== {1'b1, q[0]}) begin bad++;
        $display("FAIL ovf_pop%0d: got %b/%0h exp 1/%0h", i, valid_a, {src_a, ts_a}, q[0]); end
      tick();
    end
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b exp 0", valid_a); end
    do_clear();
    ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin err = 8'($urandom_range(1, 255)); tick(); end
    err = 8'h10; ready = 1'b1; tick(); err = 8'h00; ready = 1'b0;
    total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL full_push_pop_ovf: got %b exp 0", ovf_a); end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({valid_a, src_a, ts_a} !== {1'b1, q[0]}) begin bad++;
        $display("FAIL fpp_pop%0d: got %b/%0h exp 1/%0h", i, valid_a, {src_a, ts_a}, q[0]); end
      tick();
    end
    ready = 1'b0;
  endtask

  task automatic test_fail_delay0();
    do_clear();
    en = 1'b1; err = 8'($urandom_range(1, 255)); tick(); err = 8'h00;
    total++; if ({pend_b, halt_b, pend_a, halt_a} !== 4'b0110) begin bad++;
      $display("FAIL d0_halt: got %b exp 0110", {pend_b, halt_b, pend_a, halt_a}); end
    err = 8'h04; clr = 1'b1; tick(); clr = 1'b0; err = 8'h00;
    total++; if ({valid_a, cnt_a} !== {1'b0, 8'd0}) begin bad++;
      $display("FAIL clr_event: got v=%b c=%0d exp v=0 c=0", valid_a, cnt_a); end
    total++; if ({pend_a, halt_a, halt_b} !== 3'b000) begin bad++;
      $display("FAIL clr_fsm: got %b exp 000", {pend_a, halt_a, halt_b}); end
  endtask

  task automatic test_reset_mid();
    do_clear();
    en = 1'b1; err = 8'h80; tick(); err = 8'h00;
    for (int i = 0; i < 19; i++) tick();
    total++; if (pend_a !== 1'b1) begin bad++; $display("FAIL mid_pend: got %b exp 1", pend_a); end
    do_reset();
    for (int i = 0; i < 60; i++) begin
      tick();
      total++; if ({pend_a, halt_a} !== 2'b00) begin bad++;
        $display("FAIL mid_nohalt %0d: got %b exp 00", i, {pend_a, halt_a}); end
    end
    en = 1'b0; err = 8'hFF;
    for (int i = 0; i < 10; i++) tick();
    err = 8'h00;
    total++; if ({valid_a, cnt_a, halt_b} !== {1'b0, 8'd0, 1'b0}) begin bad++;
      $display("FAIL en_off: got v=%b c=%0d h=%b exp 0/0/0", valid_a, cnt_a, halt_b); end
  endtask

  task automatic test_saturation();
    do_clear();
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 300; i++) begin err = 8'($urandom_range(1, 255)); tick(); end
    err = 8'h00; ready = 1'b0;
    total++; if (cnt_a !== 8'd255) begin bad++; $display("FAIL cnt_sat: got %0d exp 255", cnt_a); end
  endtask

  task automatic test_random();
    do_clear();
    for (int n = 0; n < 3000; n++) begin
      en    = ($urandom_range(0, 3) != 0);
      err   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ready = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 99) == 0);
      tick();
      total++;
      if ((valid_a !== (q.size() > 0)) || ((q.size() > 0) && ({src_a, ts_a} !== q[0])) ||
          (cnt_a !== 8'(m_cnt)) || (ovf_a !== m_ovf) ||
          ({pend_a, halt_a} !== {exp_pend(first_a, DA), exp_halt(first_a, DA)}) ||
          ({pend_b, halt_b} !== {exp_pend(first_b, DB), exp_halt(first_b, DB)})) begin
        bad++;
        $display("FAIL random n=%0d: got v=%b head=%0h c=%0d o=%b a=%b%b b=%b%b exp v=%b head=%0h c=%0d o=%b a=%b%b b=%b%b",
                 n, valid_a, {src_a, ts_a}, cnt_a, ovf_a, pend_a, halt_a, pend_b, halt_b,
                 q.size() > 0, (q.size() > 0) ? q[0] : 19'd0, m_cnt, m_ovf,
                 exp_pend(first_a, DA), exp_halt(first_a, DA), exp_pend(first_b, DB), exp_halt(first_b, DB));
      end
    end
    clr = 1'b0; en = 1'b0; err = 8'h00; ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; err = 8'h00; clr = 1'b0; ready = 1'b0;
    test_reset();
    test_single_event();
    test_priority();
    test_overflow();
    test_fail_delay0();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
